// File: rtl/pifo_tree_pop_scheduler.sv
// pifo_tree_pop_scheduler
//   Pop-side scheduler for a multi-tree PIFO. Counts per-tree occupancy from
//   accepted pushes and issued pops. Picks the next tree to pop with weighted
//   round-robin. Pop commands are spaced OP_GAP cycles apart, measured from
//   one issue to the next.
//
// Ports
//   i_clk, i_arst       clock and asynchronous active-high reset
//   i_push              push presented to the PIFO this cycle
//   i_push_tree_id      target tree of that push
//   o_tree_full         per-tree: occupancy == TREE_CAP
//   o_tree_empty        per-tree: occupancy == 0
//   o_push_drop         one-cycle pulse: the previous cycle's push hit a full tree
//   i_weight_wr         weight write strobe
//   i_weight_tree_id    tree whose weight is written
//   i_weight_data       new weight (0 behaves as 1)
//   i_sched_en          scheduler enable
//   i_out_ready         downstream can take a popped element
//   o_pop               one-cycle pop command
//   o_pop_tree_id       tree being popped (valid with o_pop)
//   o_busy              FSM is not in IDLE
//
// state  | meaning
// IDLE   | waiting for enable, ready and a non-empty tree
// ISSUE  | o_pop is high for the tree chosen in the previous cycle
// GAP    | spacing cycles before the next pop may be issued
// REFILL | every credit is reloaded from its weight
//
// Pop decisions are made one cycle before the ISSUE state. The chosen tree is
// registered straight into o_pop/o_pop_tree_id. The last GAP cycle and the
// REFILL cycle are decision slots in their own right. This keeps issue-to-issue
// spacing at OP_GAP, and a refill costs exactly one bubble.
module pifo_tree_pop_scheduler #(
  parameter int TREE_NUM      = 4,
  parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
  parameter int TREE_CAP      = 340,
  parameter int CNT_BITS      = $clog2(TREE_CAP + 1),
  parameter int WEIGHT_BITS   = 4,
  parameter int OP_GAP        = 2
) (
  input  logic                     i_clk,
  input  logic                     i_arst,
  input  logic                     i_push,
  input  logic [TREE_NUM_BITS-1:0] i_push_tree_id,
  output logic [TREE_NUM-1:0]      o_tree_full,
  output logic [TREE_NUM-1:0]      o_tree_empty,
  output logic                     o_push_drop,
  input  logic                     i_weight_wr,
  input  logic [TREE_NUM_BITS-1:0] i_weight_tree_id,
  input  logic [WEIGHT_BITS-1:0]   i_weight_data,
  input  logic                     i_sched_en,
  input  logic                     i_out_ready,
  output logic                     o_pop,
  output logic [TREE_NUM_BITS-1:0] o_pop_tree_id,
  output logic                     o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_REFILL} state_e;

  localparam int GAP_BITS = (OP_GAP > 2) ? $clog2(OP_GAP - 1) : 1;
  localparam logic [GAP_BITS-1:0] GAP_LOAD = GAP_BITS'((OP_GAP > 1) ? OP_GAP - 2 : 0);
  localparam logic [CNT_BITS-1:0] CAP = CNT_BITS'(TREE_CAP);

  state_e                   state_q, state_d;
  logic [GAP_BITS-1:0]      gap_q, gap_d;
  logic [TREE_NUM_BITS-1:0] ptr_q, ptr_d;
  logic [CNT_BITS-1:0]      cnt_q    [TREE_NUM];
  logic [CNT_BITS-1:0]      cnt_d    [TREE_NUM];
  logic [WEIGHT_BITS-1:0]   weight_q [TREE_NUM];
  logic [WEIGHT_BITS-1:0]   weight_d [TREE_NUM];
  logic [WEIGHT_BITS-1:0]   credit_q [TREE_NUM];
  logic [WEIGHT_BITS-1:0]   credit_d [TREE_NUM];
  logic                     pop_q, pop_d;
  logic [TREE_NUM_BITS-1:0] pop_id_q, pop_id_d;
  logic                     drop_q, drop_d;
  logic [TREE_NUM-1:0]      full_q, full_d;
  logic [TREE_NUM-1:0]      empty_q, empty_d;

  logic [CNT_BITS-1:0]      cnt_avail  [TREE_NUM];
  logic [WEIGHT_BITS-1:0]   credit_eff [TREE_NUM];
  logic [TREE_NUM-1:0]      elig;
  logic                     any_occ;
  logic                     any_elig;
  logic [TREE_NUM_BITS-1:0] sel;
  logic [TREE_NUM_BITS-1:0] idx;
  logic                     slot;
  logic                     go;

  function automatic logic [WEIGHT_BITS-1:0] refill_val(input logic [WEIGHT_BITS-1:0] w);
    return (w == '0) ? WEIGHT_BITS'(1) : w;
  endfunction

  // Occupancy and weight bookkeeping. The pop being driven this cycle
  // (pop_q) is the one that decrements the counter.
  always_comb begin
    drop_d   = 1'b0;
    weight_d = weight_q;
    for (int t = 0; t < TREE_NUM; t++) begin
      cnt_d[t] = cnt_q[t];
      if (i_push && (i_push_tree_id == TREE_NUM_BITS'(t))) begin
        if (pop_q && (pop_id_q == TREE_NUM_BITS'(t))) begin
          cnt_d[t] = cnt_q[t];
        end else if (cnt_q[t] != CAP) begin
          cnt_d[t] = cnt_q[t] + CNT_BITS'(1);
        end else begin
          drop_d = 1'b1;
        end
      end else if (pop_q && (pop_id_q == TREE_NUM_BITS'(t)) && (cnt_q[t] != '0)) begin
        cnt_d[t] = cnt_q[t] - CNT_BITS'(1);
      end
      full_d[t]  = (cnt_d[t] == CAP);
      empty_d[t] = (cnt_d[t] == '0);
    end
    if (i_weight_wr) begin
      weight_d[i_weight_tree_id] = i_weight_data;
    end
  end

  // Eligibility ignores the pop in flight (OP_GAP == 1 decides during ISSUE).
  // In REFILL the decision sees the reloaded credits.
  always_comb begin
    any_occ  = 1'b0;
    for (int t = 0; t < TREE_NUM; t++) begin
      cnt_avail[t]  = cnt_q[t] - CNT_BITS'(pop_q && (pop_id_q == TREE_NUM_BITS'(t)));
      credit_eff[t] = (state_q == S_REFILL) ? refill_val(weight_q[t]) : credit_q[t];
      elig[t]       = (cnt_avail[t] != '0) && (credit_eff[t] != '0);
      any_occ       = any_occ | (cnt_avail[t] != '0);
    end
    any_elig = |elig;

    sel = ptr_q;
    idx = ptr_q;
    for (int k = TREE_NUM - 1; k >= 0; k--) begin
      idx = TREE_NUM_BITS'((int'(ptr_q) + k) % TREE_NUM);
      if (elig[idx]) begin
        sel = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    pop_d    = 1'b0;
    pop_id_d = pop_id_q;

    if (state_q == S_REFILL) begin
      credit_d = credit_eff;
    end

    case (state_q)
      S_ISSUE: begin
        if (OP_GAP > 1) begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_BITS'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REFILL: state_d = S_IDLE;
      default:  state_d = state_q;
    endcase

    slot = (state_q == S_IDLE) || (state_q == S_REFILL) ||
           ((state_q == S_GAP) && (gap_q == '0)) ||
           ((state_q == S_ISSUE) && (OP_GAP == 1));
    go   = slot && i_sched_en && i_out_ready && any_occ;

    if (go) begin
      if (any_elig) begin
        state_d       = S_ISSUE;
        pop_d         = 1'b1;
        pop_id_d      = sel;
        credit_d[sel] = credit_eff[sel] - WEIGHT_BITS'(1);
        if (credit_eff[sel] == WEIGHT_BITS'(1)) begin
          ptr_d = (int'(sel) == TREE_NUM - 1) ? '0 : sel + TREE_NUM_BITS'(1);
        end
      end else begin
        state_d = S_REFILL;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q  <= S_IDLE;
      gap_q    <= '0;
      ptr_q    <= '0;
      pop_q    <= 1'b0;
      pop_id_q <= '0;
      drop_q   <= 1'b0;
      full_q   <= '0;
      empty_q  <= '1;
      for (int t = 0; t < TREE_NUM; t++) begin
        cnt_q[t]    <= '0;
        weight_q[t] <= WEIGHT_BITS'(1);
        credit_q[t] <= WEIGHT_BITS'(1);
      end
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      ptr_q    <= ptr_d;
      pop_q    <= pop_d;
      pop_id_q <= pop_id_d;
      drop_q   <= drop_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      cnt_q    <= cnt_d;
      weight_q <= weight_d;
      credit_q <= credit_d;
    end
  end

  assign o_pop         = pop_q;
  assign o_pop_tree_id = pop_id_q;
  assign o_push_drop   = drop_q;
  assign o_tree_full   = full_q;
  assign o_tree_empty  = empty_q;
  assign o_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_pifo_tree_pop_scheduler.sv
module tb_pifo_tree_pop_scheduler;

  logic       clk = 1'b0;
  logic       arst;
  logic       push;
  logic [1:0] push_id;
  logic [3:0] full, empty;
  logic       drop;
  logic       wwr;
  logic [1:0] wid;
  logic [3:0] wdata;
  logic       en, ready;
  logic       pop;
  logic [1:0] pop_id;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int pop_ids[$];
  int pop_times[$];

  pifo_tree_pop_scheduler dut (
    .i_clk(clk), .i_arst(arst), .i_push(push), .i_push_tree_id(push_id),
    .o_tree_full(full), .o_tree_empty(empty), .o_push_drop(drop),
    .i_weight_wr(wwr), .i_weight_tree_id(wid), .i_weight_data(wdata),
    .i_sched_en(en), .i_out_ready(ready), .o_pop(pop), .o_pop_tree_id(pop_id),
    .o_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (!arst && pop) begin
    pop_ids.push_back(int'(pop_id));
    pop_times.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    arst = 1'b1; push = 1'b0; push_id = '0; wwr = 1'b0; wid = '0; wdata = '0;
    en = 1'b0; ready = 1'b0;
    tick(2);
    arst = 1'b0;
    tick();
    pop_ids.delete();
    pop_times.delete();
  endtask

  task automatic push_n(input int tree, input int n);
    for (int i = 0; i < n; i++) begin
      push = 1'b1; push_id = 2'(tree);
      tick();
    end
    push = 1'b0;
  endtask

  task automatic wait_pops(input string name, input int n, input int budget);
    int b = 0;
    while (pop_ids.size() < n && b < budget) begin
      tick();
      b++;
    end
    tick(10);
    chk({name, "_count"}, pop_ids.size(), n);
  endtask

  task automatic chk_ids(input string name, input int exp[$]);
    for (int i = 0; i < exp.size(); i++) begin
      chk($sformatf("%s_id%0d", name, i), (i < pop_ids.size()) ? pop_ids[i] : 32'hff, exp[i]);
    end
  endtask

  typedef struct {
    logic       push;
    logic [1:0] tid;
    logic [3:0] exp_empty;
    logic       exp_drop;
  } vec_t;

  vec_t vecs[7];
  int exp1[$];
  int expw[$];
  int exp0[$];
  int b;

  initial begin
    vecs[0] = '{1'b1, 2'd1, 4'b1101, 1'b0};
    vecs[1] = '{1'b0, 2'd0, 4'b1101, 1'b0};
    vecs[2] = '{1'b1, 2'd3, 4'b0101, 1'b0};
    vecs[3] = '{1'b1, 2'd3, 4'b0101, 1'b0};
    vecs[4] = '{1'b1, 2'd0, 4'b0100, 1'b0};
    vecs[5] = '{1'b1, 2'd2, 4'b0000, 1'b0};
    vecs[6] = '{1'b0, 2'd0, 4'b0000, 1'b0};

    // reset values
    arst = 1'b1; push = 1'b0; push_id = '0; wwr = 1'b0; wid = '0; wdata = '0;
    en = 1'b0; ready = 1'b0;
    #1;
    chk("rst_pop", pop, 0);
    chk("rst_pop_id", pop_id, 0);
    chk("rst_drop", drop, 0);
    chk("rst_empty", empty, 4'b1111);
    chk("rst_full", full, 4'b0000);
    chk("rst_busy", busy, 0);
    do_reset();

    // occupancy table
    for (int i = 0; i < 7; i++) begin
      push = vecs[i].push; push_id = vecs[i].tid;
      tick();
      chk($sformatf("vec%0d_empty", i), empty, vecs[i].exp_empty);
      chk($sformatf("vec%0d_drop", i), drop, vecs[i].exp_drop);
    end
    push = 1'b0;

    // round-robin, weights 1, 12 pops
    do_reset();
    push_n(1, 4); push_n(2, 4); push_n(3, 4);
    en = 1'b1; ready = 1'b1;
    exp1 = '{1,2,3,1,2,3,1,2,3,1,2,3};
    wait_pops("rr", 12, 100);
    chk_ids("rr", exp1);
    for (int i = 1; i < 12 && i < pop_times.size(); i++) begin
      chk($sformatf("rr_gap%0d", i), pop_times[i] - pop_times[i-1], (i % 3 == 0) ? 3 : 2);
    end
    chk("rr_empty_end", empty, 4'b1111);
    chk("rr_busy_end", busy, 0);

    // weighted: t1=3, t2=1
    do_reset();
    wwr = 1'b1; wid = 2'd1; wdata = 4'd3; tick();
    wwr = 1'b0;
    push_n(1, 8); push_n(2, 8);
    en = 1'b1; ready = 1'b1;
    expw = '{1,2,1,1,1,2,1,1,1,2,1,2,2,2,2,2};
    wait_pops("wrr", 16, 200);
    chk_ids("wrr", expw);
    chk("wrr_empty_end", empty, 4'b1111);

    // fill tree 0, drop, same-cycle push+pop
    do_reset();
    push_n(0, 339);
    chk("full_339", full, 4'b0000);
    push_n(0, 1);
    chk("full_340", full, 4'b0001);
    chk("full_340_drop", drop, 0);
    push = 1'b1; push_id = 2'd0; tick();
    push = 1'b0;
    chk("drop_pulse", drop, 1);
    tick();
    chk("drop_single", drop, 0);
    chk("full_after_drop", full, 4'b0001);
    en = 1'b1; ready = 1'b1;
    b = 0;
    while (!pop && b < 20) begin tick(); b++; end
    chk("full_pop_seen", pop, 1);
    chk("full_pop_id", pop_id, 0);
    push = 1'b1; push_id = 2'd0; en = 1'b0;
    tick();
    push = 1'b0;
    chk("pushpop_nodrop", drop, 0);
    chk("pushpop_full", full, 4'b0001);
    tick(3);
    push = 1'b1; push_id = 2'd0; tick();
    push = 1'b0;
    chk("pushpop_cnt_kept", drop, 1);

    // ready low holds pops off
    do_reset();
    push_n(1, 2);
    en = 1'b1; ready = 1'b0;
    b = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (pop) b++; end
    chk("noready_pops", b, 0);
    chk("noready_busy", busy, 0);
    ready = 1'b1;
    tick();
    chk("ready_pop", pop, 1);
    chk("ready_pop_id", pop_id, 1);
    tick();
    chk("gap_busy", busy, 1);
    chk("gap_nopop", pop, 0);

    // reset during GAP
    arst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_empty", empty, 4'b1111);
    chk("arst_pop", pop, 0);
    tick();
    arst = 1'b0;
    pop_ids.delete();
    tick(12);
    chk("arst_no_pop", pop_ids.size(), 0);
    push_n(3, 1);
    exp0 = '{3};
    wait_pops("arst_newpush", 1, 20);
    chk_ids("arst_newpush", exp0);

    // weight 0 acts as 1
    do_reset();
    wwr = 1'b1; wid = 2'd2; wdata = 4'd0; tick();
    wwr = 1'b0;
    push_n(1, 2); push_n(2, 2); push_n(3, 2);
    en = 1'b1; ready = 1'b1;
    exp1 = '{1,2,3,1,2,3};
    wait_pops("w0", 6, 60);
    chk_ids("w0", exp1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
